// File: rtl/instr_sequencer.sv
// Multicycle fetch/decode/control sequencer for the register_8BITS + MUX_2X1 + ULA datapath.
// Instruction flow: FETCH -> WAIT (ROM latency) -> EXEC -> [WB] -> FETCH, with a sticky HALT.
module instr_sequencer #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 24
) (
  input  logic               clock_reg,
  input  logic               reset,
  input  logic               run,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               ula_zero,
  output logic [PC_W-1:0]    imem_addr,
  output logic               reg_we,
  output logic [2:0]         reg_wa,
  output logic [2:0]         reg_ra1,
  output logic [2:0]         reg_ra2,
  output logic               alu_src,
  output logic [2:0]         ula_ctrl,
  output logic [7:0]         imm_out,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_WAIT  = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [1:0] OP_ALU_REG = 2'b00;
  localparam logic [1:0] OP_ALU_IMM = 2'b01;
  localparam logic [1:0] OP_BEQZ    = 2'b10;
  localparam logic [1:0] OP_HALT    = 2'b11;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;

  logic [1:0]      op;
  logic [PC_W-1:0] branchOffset;
  logic            unused_irBits;

  assign op            = ir_q[23:22];
  assign branchOffset  = PC_W'(signed'(ir_q[7:0]));
  assign unused_irBits = ^ir_q[9:8];

  always_ff @(posedge clock_reg) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // run only matters in FETCH, so an instruction already under way always finishes.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_FETCH: if (run) state_d = S_WAIT;
      S_WAIT: begin
        ir_d    = imem_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        unique case (op)
          OP_ALU_REG, OP_ALU_IMM: state_d = S_WB;
          OP_BEQZ: begin
            pc_d    = ula_zero ? pc_q + branchOffset : pc_q + PC_W'(1);
            state_d = S_FETCH;
          end
          OP_HALT: state_d = S_HALT;
          default: state_d = S_FETCH;
        endcase
      end
      S_WB: begin
        pc_d    = pc_q + PC_W'(1);
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // WB repeats the EXEC read-side controls so ULAResult stays stable while it is written.
  always_comb begin
    imem_addr = pc_q;
    pc        = pc_q;
    state_dbg = state_q;
    halted    = (state_q == S_HALT);
    reg_we    = 1'b0;
    reg_wa    = '0;
    reg_ra1   = '0;
    reg_ra2   = '0;
    alu_src   = 1'b0;
    ula_ctrl  = '0;
    imm_out   = '0;
    if (state_q == S_EXEC || state_q == S_WB) begin
      reg_ra1  = ir_q[15:13];
      reg_ra2  = ir_q[12:10];
      ula_ctrl = ir_q[21:19];
      imm_out  = ir_q[7:0];
      alu_src  = (op == OP_ALU_IMM);
    end
    if (state_q == S_WB) begin
      reg_we = 1'b1;
      reg_wa = ir_q[18:16];
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a ROM-driven program, an instruction-level reference
// model checked every cycle, and hand-computed literal checks at key points.
module tb_instr_sequencer;

  logic        clock_reg = 1'b0;
  logic        reset;
  logic        run;
  logic [23:0] imem_data;
  logic        ula_zero;
  logic [7:0]  imem_addr;
  logic        reg_we;
  logic [2:0]  reg_wa;
  logic [2:0]  reg_ra1;
  logic [2:0]  reg_ra2;
  logic        alu_src;
  logic [2:0]  ula_ctrl;
  logic [7:0]  imm_out;
  logic [7:0]  pc;
  logic        halted;
  logic [2:0]  state_dbg;

  int vectors     = 0;
  int miscompares = 0;

  logic [23:0] rom [0:255];

  instr_sequencer #(.PC_W(8), .INSTR_W(24)) dut (
    .clock_reg (clock_reg),
    .reset     (reset),
    .run       (run),
    .imem_data (imem_data),
    .ula_zero  (ula_zero),
    .imem_addr (imem_addr),
    .reg_we    (reg_we),
    .reg_wa    (reg_wa),
    .reg_ra1   (reg_ra1),
    .reg_ra2   (reg_ra2),
    .alu_src   (alu_src),
    .ula_ctrl  (ula_ctrl),
    .imm_out   (imm_out),
    .pc        (pc),
    .halted    (halted),
    .state_dbg (state_dbg)
  );

  always #5 clock_reg = ~clock_reg;

  // Synchronous ROM: data for the address seen at an edge appears after that edge.
  always @(posedge clock_reg) imem_data <= rom[imem_addr];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference model: position within the current instruction (0 idle in fetch, 1 awaiting ROM,
  // 2 execute, 3 write-back) plus the architectural pc and the instruction being executed.
  int          mStep      = 0;
  int          mPc        = 0;
  logic [23:0] mInstr     = '0;
  bit          mHalt      = 1'b0;
  bit          modelValid = 1'b0;

  function automatic logic [41:0] expectedOutputs(int step, logic [23:0] instr, int curPc,
                                                  bit isHalt);
    logic [7:0] addr;
    logic       we, src;
    logic [2:0] wa, ra1, ra2, ctrl, st;
    logic [7:0] imm;
    addr = 8'(curPc);
    we = 0; src = 0; wa = 0; ra1 = 0; ra2 = 0; ctrl = 0; imm = 0;
    st = isHalt ? 3'd4 : 3'(step);
    if (!isHalt && step >= 2) begin
      ra1  = instr[15:13];
      ra2  = instr[12:10];
      ctrl = instr[21:19];
      imm  = instr[7:0];
      src  = (instr[23:22] == 2'b01);
    end
    if (!isHalt && step == 3) begin
      we = 1;
      wa = instr[18:16];
    end
    return {addr, we, wa, ra1, ra2, src, ctrl, imm, addr, isHalt, st};
  endfunction

  always @(posedge clock_reg) begin
    if (reset === 1'b0) begin
      mStep = 0; mPc = 0; mInstr = '0; mHalt = 0; modelValid = 1;
    end else if (modelValid && !mHalt) begin
      if (mStep == 0) begin
        if (run) mStep = 1;
      end else if (mStep == 1) begin
        mInstr = rom[mPc];
        mStep  = 2;
      end else if (mStep == 2) begin
        if (mInstr[23] == 1'b0) mStep = 3;
        else if (mInstr[22] == 1'b1) begin
          mHalt = 1; mStep = 0;
        end else begin
          int off;
          off   = (mInstr[7:0] >= 128) ? int'(mInstr[7:0]) - 256 : int'(mInstr[7:0]);
          mPc   = ula_zero ? (mPc + off + 256) % 256 : (mPc + 1) % 256;
          mStep = 0;
        end
      end else begin
        mPc   = (mPc + 1) % 256;
        mStep = 0;
      end
    end
  end

  always @(negedge clock_reg) begin
    if (modelValid)
      checkOutput("cycle outputs",
                  {imem_addr, reg_we, reg_wa, reg_ra1, reg_ra2, alu_src, ula_ctrl, imm_out,
                   pc, halted, state_dbg},
                  expectedOutputs(mStep, mInstr, mPc, mHalt));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock_reg);
  endtask

  task automatic applyStimulus();
    reset = 0; run = 0; ula_zero = 1;
    repeat (2) @(posedge clock_reg);
    tick(1);
    checkOutput("reset imem_addr", imem_addr, 0);
    checkOutput("reset pc", pc, 0);
    checkOutput("reset reg_we", reg_we, 0);
    checkOutput("reset state", state_dbg, 0);
    reset = 1; run = 1;
    tick(1);
    checkOutput("fetch->wait", state_dbg, 1);
    tick(1);
    checkOutput("addi alu_src", alu_src, 1);
    checkOutput("addi imm", imm_out, 8'h07);
    checkOutput("addi ra1", reg_ra1, 0);
    tick(1);
    checkOutput("addi reg_we", reg_we, 1);
    checkOutput("addi reg_wa", reg_wa, 3);
    checkOutput("addi alu_src held", alu_src, 1);
    tick(1);
    checkOutput("pc after addi", pc, 1);
    tick(2);
    checkOutput("beqz alu_src", alu_src, 0);
    checkOutput("beqz ula_ctrl", ula_ctrl, 3'b001);
    tick(1);
    checkOutput("beqz taken backward wrap", pc, 8'hFF);
    tick(4);
    checkOutput("pc wrap after wb", pc, 8'h00);
    checkOutput("imem_addr wrap", imem_addr, 8'h00);
    ula_zero = 0;
    tick(4);
    checkOutput("pc before beqz", pc, 1);
    tick(3);
    checkOutput("beqz not taken", pc, 2);
    tick(3);
    checkOutput("wb before park", reg_we, 1);
    run = 0;
    tick(3);
    checkOutput("parked state", state_dbg, 0);
    checkOutput("parked pc", pc, 3);
    run = 1;
    tick(1);
    checkOutput("resume to wait", state_dbg, 1);
    tick(3);
    checkOutput("pc after alu-reg", pc, 4);
    tick(3);
    checkOutput("pc at halt instr", pc, 5);
    tick(3);
    checkOutput("halted", halted, 1);
    for (int i = 0; i < 6; i++) begin
      run = i[0];
      tick(1);
    end
    checkOutput("halt sticky", halted, 1);
    checkOutput("halt pc", pc, 5);
    checkOutput("halt state", state_dbg, 4);
    run = 0; reset = 0;
    tick(1);
    reset = 1;
    checkOutput("unhalt state", state_dbg, 0);
    checkOutput("unhalt pc", pc, 0);
    checkOutput("unhalt halted", halted, 0);
    run = 1;
    tick(3);
    reset = 0;
    #1 checkOutput("write in reset cycle", reg_we, 1);
    tick(1);
    checkOutput("after wb reset we", reg_we, 0);
    checkOutput("after wb reset pc", pc, 0);
    reset = 1; run = 0;
    tick(3);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 24'h000000;
    rom[0]   = 24'h430007;
    rom[1]   = 24'h8848FE;
    rom[2]   = 24'h598080;
    rom[3]   = 24'h27D455;
    rom[4]   = 24'h882410;
    rom[5]   = 24'hC00000;
    rom[255] = 24'h152800;
    applyStimulus();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
